// File: rtl/ballot_controller.sv
// Ballot front end: debounces the officer and candidate keys, allows one vote per issued ballot,
// and keeps saturating audit counters. Define BALLOT_TIMEOUT_EN to compile in the ARMED timeout.
module ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 12,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       ballot_req,
  input  logic [3:0] buttons_raw,
  output logic [3:0] vote_pulse,
  output logic       ready_led,
  output logic       reject_led,
  output logic [7:0] ballots_issued,
  output logic [7:0] ballots_cast,
  output logic [7:0] ballots_expired
);

  typedef enum logic [1:0] {IDLE, ARMED, CAST, RELEASE} state_e;

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCW = $clog2(PULSE_CYCLES + 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bit 4 is the officer key, bits 3:0 the candidate keys.
  logic [4:0]     raw_in;
  logic [4:0]     sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DCW-1:0] dcnt_q [5];

  assign raw_in = {ballot_req, buttons_raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      // NOTE: this small counter array is control state, so it is reset like any other register.
      for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]  <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [3:0] keys;
  logic        key_rise, req_rise, one_key, multi_key, no_key;

  assign keys      = deb_q[3:0];
  assign key_rise  = |(deb_q[3:0] & ~deb_prev_q[3:0]);
  assign req_rise  = deb_q[4] & ~deb_prev_q[4];
  assign one_key   = ($countones(keys) == 1);
  assign multi_key = ($countones(keys) > 1);
  assign no_key    = (keys == 4'b0000);

  state_e         state_q;
  logic [3:0]     pulse_q;
  logic [PCW-1:0] pcnt_q;
  logic           ready_q, reject_q, blocked_q;
  logic [7:0]     issued_q, cast_q;
`ifdef BALLOT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] tmr_q;
  logic [7:0]     expired_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pulse_q   <= '0;
      pcnt_q    <= '0;
      ready_q   <= 1'b0;
      reject_q  <= 1'b0;
      blocked_q <= 1'b0;
      issued_q  <= '0;
      cast_q    <= '0;
`ifdef BALLOT_TIMEOUT_EN
      tmr_q     <= '0;
      expired_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_rise && !mode && no_key) begin
            state_q   <= ARMED;
            ready_q   <= 1'b1;
            blocked_q <= 1'b0;
            issued_q  <= sat_inc(issued_q);
`ifdef BALLOT_TIMEOUT_EN
            tmr_q     <= '0;
`endif
          end
        end
        ARMED: begin
`ifdef BALLOT_TIMEOUT_EN
          tmr_q <= tmr_q + 1'b1;
`endif
          // A multi-key press locks out voting until every key is back up.
          if (multi_key) begin
            blocked_q <= 1'b1;
            reject_q  <= 1'b1;
          end else if (no_key) begin
            blocked_q <= 1'b0;
          end
          if (mode) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            reject_q <= 1'b0;
          end else if (key_rise && one_key && !blocked_q) begin
            state_q  <= CAST;
            ready_q  <= 1'b0;
            reject_q <= 1'b0;
            pulse_q  <= keys;
            pcnt_q   <= '0;
            cast_q   <= sat_inc(cast_q);
`ifdef BALLOT_TIMEOUT_EN
          // Fires in the TIMEOUT_CYCLES-th ARMED cycle, so ready_led is high that many cycles.
          end else if (tmr_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            reject_q  <= 1'b0;
            expired_q <= sat_inc(expired_q);
`endif
          end
        end
        CAST: begin
          if (pcnt_q == PCW'(PULSE_CYCLES - 1)) begin
            pulse_q <= '0;
            state_q <= RELEASE;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (no_key) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vote_pulse     = pulse_q;
  assign ready_led      = ready_q;
  assign reject_led     = reject_q;
  assign ballots_issued = issued_q;
  assign ballots_cast   = cast_q;
`ifdef BALLOT_TIMEOUT_EN
  assign ballots_expired = expired_q;
`else
  assign ballots_expired = 8'd0;
`endif

endmodule

// File: tb/tb_ballot_controller.sv
// Self-checking bench for ballot_controller: directed scenarios plus randomized ballots,
// with expected counters and pulse timing derived from the ballot rules.
module tb_ballot_controller;
  localparam int D = 4;
  localparam int P = 3;
  localparam int T = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic       ballot_req = 1'b0;
  logic [3:0] buttons_raw = 4'b0000;
  logic [3:0] vote_pulse;
  logic       ready_led, reject_led;
  logic [7:0] ballots_issued, ballots_cast, ballots_expired;

  int checks = 0;
  int errors = 0;
  int exp_issued = 0;
  int exp_cast = 0;
  int exp_expired = 0;

  ballot_controller #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mode           (mode),
    .ballot_req     (ballot_req),
    .buttons_raw    (buttons_raw),
    .vote_pulse     (vote_pulse),
    .ready_led      (ready_led),
    .reject_led     (reject_led),
    .ballots_issued (ballots_issued),
    .ballots_cast   (ballots_cast),
    .ballots_expired(ballots_expired)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".issued"},  32'(ballots_issued),  32'(exp_issued));
    check({tag, ".cast"},    32'(ballots_cast),    32'(exp_cast));
    check({tag, ".expired"}, 32'(ballots_expired), 32'(exp_expired));
  endtask

  task automatic settle();
    buttons_raw = 4'b0000;
    ballot_req  = 1'b0;
    mode        = 1'b0;
    tick(D + 4);
  endtask

  // Officer key edge reaches ARMED D+3 cycles later.
  task automatic issue();
    ballot_req = 1'b1;
    tick(D + 2);
    check("issue.pre_ready", 32'(ready_led), 32'd0);
    tick();
    exp_issued = sat(exp_issued + 1);
    check("issue.ready", 32'(ready_led), 32'd1);
    check("issue.count", 32'(ballots_issued), 32'(exp_issued));
    ballot_req = 1'b0;
  endtask

  // Raw key edge to first pulse cycle is D+3; pulse lasts exactly P cycles.
  task automatic vote(input int k);
    logic [3:0] oh;
    int hi;
    oh = 4'(1 << k);
    buttons_raw = oh;
    tick(D + 2);
    check("vote.no_early_pulse", 32'(vote_pulse), 32'd0);
    tick();
    exp_cast = sat(exp_cast + 1);
    check("vote.first_pulse", 32'(vote_pulse), 32'(oh));
    check("vote.cast", 32'(ballots_cast), 32'(exp_cast));
    check("vote.ready_off", 32'(ready_led), 32'd0);
    check("vote.reject_off", 32'(reject_led), 32'd0);
    hi = 1;
    repeat (P + 2) begin
      tick();
      if (vote_pulse == oh) hi++;
      else if (vote_pulse != 4'b0000) hi += 100;
    end
    check("vote.pulse_width", 32'(hi), 32'(P));
    buttons_raw = 4'b0000;
    tick(D + 4);
  endtask

  initial begin
    int k, nz, len, rdy;
    logic [3:0] oh;

    // Reset state
    #12;
    check("reset.pulse", 32'(vote_pulse), 32'd0);
    check("reset.ready", 32'(ready_led), 32'd0);
    check("reset.reject", 32'(reject_led), 32'd0);
    check_counters("reset");
    #10 reset = 1'b1;
    tick(2);

    // Single vote on candidate 2
    issue();
    vote(2);
    check_counters("single");

    // Double vote without a new ballot
    buttons_raw = 4'b1000;
    nz = 0;
    repeat (D + 8) begin
      tick();
      if (vote_pulse != 4'b0000) nz++;
    end
    check("double.no_pulse", 32'(nz), 32'd0);
    check("double.ready", 32'(ready_led), 32'd0);
    check_counters("double");
    settle();

    // Multi-key press, release, then single key
    issue();
    buttons_raw = 4'b0011;
    tick(D + 3);
    check("multi.reject", 32'(reject_led), 32'd1);
    check("multi.ready", 32'(ready_led), 32'd1);
    check("multi.no_pulse", 32'(vote_pulse), 32'd0);
    buttons_raw = 4'b0000;
    tick(D + 1);
    vote(0);
    check_counters("multi");
    settle();

    // Bounce on key 0 every 2 cycles for 20 cycles
    issue();
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      buttons_raw = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (vote_pulse != 4'b0000) nz++;
    end
    buttons_raw = 4'b0000;
    repeat (D + 4) begin
      tick();
      if (vote_pulse != 4'b0000) nz++;
    end
    check("bounce.no_pulse", 32'(nz), 32'd0);
`ifdef BALLOT_TIMEOUT_EN
    exp_expired = sat(exp_expired + 1);
    check("bounce.expired_ready", 32'(ready_led), 32'd0);
`else
    check("bounce.still_armed", 32'(ready_led), 32'd1);
    mode = 1'b1;
    tick();
    check("bounce.abort", 32'(ready_led), 32'd0);
`endif
    check_counters("bounce");
    settle();

    // Mode=1 and a valid key edge in the same ARMED cycle: abort wins
    issue();
    buttons_raw = 4'b0010;
    tick(D + 2);
    mode = 1'b1;
    tick();
    check("abortwin.ready", 32'(ready_led), 32'd0);
    check("abortwin.pulse", 32'(vote_pulse), 32'd0);
    tick(P + 2);
    check("abortwin.pulse_later", 32'(vote_pulse), 32'd0);
    check_counters("abortwin");
    settle();

    // Requests ignored with mode=1 or with a key held
    mode = 1'b1;
    ballot_req = 1'b1;
    tick(D + 4);
    check("req_mode.ready", 32'(ready_led), 32'd0);
    check_counters("req_mode");
    settle();
    buttons_raw = 4'b0001;
    tick(D + 4);
    ballot_req = 1'b1;
    tick(D + 4);
    check("req_key.ready", 32'(ready_led), 32'd0);
    check_counters("req_key");
    settle();

    // Timeout (or indefinite wait when compiled out)
    issue();
    rdy = 1;
    repeat (100) begin
      tick();
      if (ready_led) rdy++;
    end
`ifdef BALLOT_TIMEOUT_EN
    exp_expired = sat(exp_expired + 1);
    check("timeout.ready_cycles", 32'(rdy), 32'(T));
`else
    check("timeout.ready_cycles", 32'(rdy), 32'd101);
    mode = 1'b1;
    tick();
`endif
    check("timeout.ready_off", 32'(ready_led), 32'd0);
    check_counters("timeout");
    settle();

    // Randomized ballots
    for (int it = 0; it < 16; it++) begin
      k  = $urandom_range(0, 3);
      oh = 4'(1 << k);
      case ($urandom_range(0, 2))
        0: begin
          issue();
          tick($urandom_range(0, 5));
          vote(k);
        end
        1: begin
          issue();
          tick($urandom_range(0, 5));
          mode = 1'b1;
          tick();
          check("rnd_abort.ready", 32'(ready_led), 32'd0);
          check("rnd_abort.reject", 32'(reject_led), 32'd0);
        end
        default: begin
          issue();
          nz = 0;
          for (int ph = 0; ph < 3; ph++) begin
            buttons_raw = (ph % 2 == 0) ? oh : 4'b0000;
            len = $urandom_range(1, D - 1);
            repeat (len) begin
              tick();
              if (vote_pulse != 4'b0000) nz++;
            end
          end
          buttons_raw = 4'b0000;
          repeat ($urandom_range(1, 2)) begin
            tick();
            if (vote_pulse != 4'b0000) nz++;
          end
          check("rnd_glitch.no_pulse", 32'(nz), 32'd0);
          check("rnd_glitch.armed", 32'(ready_led), 32'd1);
          vote(k);
        end
      endcase
      check_counters("rnd");
      settle();
    end

    // Drive ballots_issued to saturation
    while (exp_issued < 255) begin
      issue();
      mode = 1'b1;
      tick();
      mode = 1'b0;
      settle();
    end
    issue();
    check("sat.issued_held", 32'(ballots_issued), 32'd255);
    mode = 1'b1;
    tick();
    check_counters("sat");
    settle();

    // Asynchronous reset in the middle of CAST
    issue();
    buttons_raw = 4'b0100;
    tick(D + 3);
    check("rst.pulse_before", 32'(vote_pulse), 32'h4);
    tick();
    #2 reset = 1'b0;
    #1;
    exp_issued  = 0;
    exp_cast    = 0;
    exp_expired = 0;
    check("rst.pulse_dropped", 32'(vote_pulse), 32'd0);
    check("rst.ready", 32'(ready_led), 32'd0);
    check_counters("rst");
    buttons_raw = 4'b0000;
    tick(3);
    reset = 1'b1;
    nz = 0;
    repeat (D + 6) begin
      tick();
      if (vote_pulse != 4'b0000) nz++;
    end
    check("rst.no_resume", 32'(nz), 32'd0);
    check_counters("rst_after");

    // Normal operation after reset
    issue();
    vote(3);
    check_counters("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ballot_controller.md
# ballot_controller

Voter-facing front end of the EVM, directly upstream of the per-candidate button stages. It debounces the raw officer "issue ballot" key and the four candidate keys. It allows exactly one vote per issued ballot and drives a clean, fixed-width high pulse on one candidate line into the EVM `buttons` inputs. It also keeps ballot bookkeeping counters for audit against the downstream tallies.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a debounced level changes.
- `PULSE_CYCLES`, 12: width in clocks of each `vote_pulse` assertion.
- `TIMEOUT_CYCLES`, 1000: clocks a voter has to vote after a ballot is issued.
- `clock` in 1: single system clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mode` in 1: 0 = voting, 1 = result display; voting is disabled when 1.
- `ballot_req` in 1: raw officer key, asynchronous.
- `buttons_raw` in 4: raw candidate keys, asynchronous, active-high.
- `vote_pulse` out 4: one-hot candidate pulse to the EVM `buttons` inputs.
- `ready_led` out 1: high while a ballot is issued and awaiting a vote.
- `reject_led` out 1: high for the ballot after a multi-key press is seen.
- `ballots_issued` out 8: ballots issued, saturating at 255.
- `ballots_cast` out 8: votes emitted, saturating at 255.
- `ballots_expired` out 8: ballots that timed out, saturating at 255.

## Operation
- Each raw input passes through a 2-flop synchronizer, then a per-input stability counter.
- The debounced level takes the synchronized value once that value has differed from the current debounced level for `DEBOUNCE_CYCLES` consecutive cycles.
- Any mismatch-free cycle clears that input's counter.
- FSM states: IDLE, ARMED, CAST, RELEASE.
- IDLE:
  - A debounced `ballot_req` rising edge with `mode`=0 and all debounced keys released moves the FSM to ARMED.
  - On that edge, `ballots_issued` increments and the timeout counter loads 0.
  - A request with `mode`=1 or with any key held is ignored.
- ARMED:
  - A debounced key rising edge with exactly one debounced key high moves the FSM to CAST.
  - That key is latched as the selected candidate.
  - More than one debounced key high sets `reject_led`; the FSM stays in ARMED and accepts the next single-key edge only after all keys have been released.
  - `mode`=1 moves the FSM to IDLE with no count change.
  - Timeout reached moves the FSM to IDLE and increments `ballots_expired`.
- CAST:
  - `vote_pulse` equals the latched one-hot value for exactly `PULSE_CYCLES` cycles, then the FSM moves to RELEASE.
  - `ballots_cast` increments on CAST entry.
  - `mode` changes do not abort CAST.
- RELEASE: waits until all debounced keys are low, then moves to IDLE.
- `ready_led` = (state == ARMED).
- `reject_led` clears on leaving ARMED.
- `ballot_req` held or re-pressed outside IDLE has no effect; each ballot needs a fresh edge in IDLE.
- All counters saturate at 255 and never wrap.

## Timing
- Reset values:
  - state IDLE
  - `vote_pulse`=0, `ready_led`=0, `reject_led`=0
  - all three counters 0
  - all debounced levels 0, all synchronizers 0
- Clean raw edge to debounced change: `DEBOUNCE_CYCLES`+2 cycles.
- Debounced edge to state change: 1 cycle, registered.
- Raw key edge to first `vote_pulse` cycle: `DEBOUNCE_CYCLES`+3 cycles.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles never change a debounced level.
- Timeout fires on the cycle the ARMED dwell count equals `TIMEOUT_CYCLES`.
- If a valid key edge and the timeout land in the same cycle, the vote wins.
- If `mode`=1 and a valid key edge land in the same cycle in ARMED, the abort wins.
- Reset asserted mid-CAST drops `vote_pulse` immediately (asynchronous); no partial pulse is resumed after reset.
- `vote_pulse` is fully registered, so downstream sees no combinational path from the raw inputs.

## Configuration
- `BALLOT_TIMEOUT_EN` defined:
  - The ARMED dwell counter and timeout transition are compiled in.
  - `ballots_expired` counts expiries.
- `BALLOT_TIMEOUT_EN` undefined:
  - There is no dwell counter; ARMED waits indefinitely and leaves only on a vote or `mode`=1.
  - `ballots_expired` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `PULSE_CYCLES`=3, `TIMEOUT_CYCLES`=20, and `BALLOT_TIMEOUT_EN` defined unless noted.
- Single vote:
  - Stimulus: `ballot_req` pulse 10 cycles, then `buttons_raw`=4'b0100 held 10 cycles.
  - Response: `ready_led` high in ARMED; `vote_pulse`=4'b0100 for exactly 3 cycles, starting 7 cycles after the raw key edge.
  - Counters: `ballots_issued`=1, `ballots_cast`=1.
- Bounce rejection:
  - Stimulus: in ARMED, key 0 toggled every 2 cycles for 20 cycles, then released.
  - Response: `vote_pulse` stays 0; `ballots_cast` stays 0.
- Multi-key:
  - Stimulus: in ARMED, 4'b0011 held 10 cycles, released, then 4'b0001 held 10 cycles.
  - Response: `reject_led`=1 after the first press; a single `vote_pulse`=4'b0001 follows; `reject_led`=0 afterwards.
- Double vote blocked:
  - Stimulus: after a cast, press 4'b1000 again without a new ballot.
  - Response: no pulse; `ballots_cast` unchanged.
- Timeout:
  - Stimulus: issue a ballot, apply no keys.
  - Response: after 20 cycles in ARMED, the FSM returns to IDLE with `ready_led`=0 and `ballots_expired`=1.
  - Rerun with `BALLOT_TIMEOUT_EN` undefined: stays ARMED for 100 cycles.
- Mode and reset:
  - Stimulus: `mode`=1 while ARMED.
  - Response: IDLE next cycle with counters unchanged.
  - Stimulus: `reset`=0 during CAST.
  - Response: `vote_pulse`=0 at once; all counters 0.
